// File: rtl/mux_scan_sampler_pkg.sv
// rtl/mux_scan_sampler_pkg.sv - shared types and sizes for the mux scan sampler
package mux_scan_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sampler_if.sv
// rtl/mux_scan_sampler_if.sv - captured-byte valid/ready handshake bundle
interface mux_scan_sampler_if;

  logic [mux_scan_pkg::N_CH-1:0] data_out;
  logic                          valid;
  logic                          ready;

  modport master (
    output data_out,
    output valid,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    output ready
  );

endinterface

// File: rtl/mux_scan_sampler_settle_timer.sv
// rtl/mux_scan_sampler_settle_timer.sv - per-channel settle down-counter with zero flag
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - steps an 8:1 mux select and packs the sampled bits into a byte
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               y,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  mux_scan_sampler_if.master bus,
  output logic               busy
);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_CH-1:0]   shadow_q, shadow_d;
  logic [N_CH-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              tmr_load, tmr_dec, tmr_zero;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State and datapath registers; reset drops any partial or pending frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state: hold each select for SETTLE_CYCLES+1 clocks, sample y on the last one.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d    = '0;
          shadow_d = '0;
          tmr_load = 1'b1;
          busy_d   = 1'b1;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else begin
          shadow_d[sel_q] = y;
          if (sel_q == SEL_W'(N_CH - 1)) begin
            // Publish the whole frame at once, last bit included.
            data_d  = shadow_d;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            sel_d    = sel_q + SEL_W'(1);
            tmr_load = 1'b1;
          end
        end
      end

      DONE: begin
        // start is deliberately ignored here, even alongside ready.
        if (bus.ready) begin
          valid_d = 1'b0;
          sel_d   = '0;
          if (CONTINUOUS) begin
            shadow_d = '0;
            tmr_load = 1'b1;
            busy_d   = 1'b1;
            state_d  = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s0           = sel_q[0];
  assign s1           = sel_q[1];
  assign s2           = sel_q[2];
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign busy         = busy_q;

endmodule
